// File: rtl/mult_err_stats.sv
// Error statistics for the 16x16 approximate signed multiplier.
// Optional worst-sample operand capture: MAXERR_CAPTURE_EN.
module mult_err_stats #(
  parameter int N_SAMPLES = 256,
  parameter int CNT_W     = $clog2(N_SAMPLES) + 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_start,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [15:0]                        i_a,
  input  logic [15:0]                        i_b,
  input  logic [31:0]                        i_z,
  output logic                               o_done,
  output logic [34+$clog2(N_SAMPLES)-1:0]    o_sum_err,
  output logic [33+$clog2(N_SAMPLES)-1:0]    o_sum_abs,
  output logic [32:0]                        o_max_abs,
  output logic [CNT_W-1:0]                   o_nz_cnt,
  output logic [15:0]                        o_max_a,
  output logic [15:0]                        o_max_b
);

  localparam int LG   = $clog2(N_SAMPLES);
  localparam int SE_W = 34 + LG;
  localparam int SA_W = 33 + LG;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [1:0] drn_q, drn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept, last, clr;

  logic               s1_vld_q, s1_vld_d;
  logic signed [15:0] a_s1_q, a_s1_d;
  logic signed [15:0] b_s1_q, b_s1_d;
  logic signed [31:0] z_s1_q, z_s1_d;

  logic               s2_vld_q, s2_vld_d;
  logic signed [32:0] err_s2_q, err_s2_d;
  logic [32:0]        abs_s2_q, abs_s2_d;
  logic signed [31:0] exact;

  logic [SE_W-1:0]  sum_err_q, sum_err_d;
  logic [SA_W-1:0]  sum_abs_q, sum_abs_d;
  logic [32:0]      max_abs_q, max_abs_d;
  logic [CNT_W-1:0] nz_q, nz_d;
  logic             upd_max;

  assign accept = i_valid && (state_q == S_RUN);
  assign last   = accept && (cnt_q == CNT_W'(N_SAMPLES - 1));
  assign clr    = i_start &&
                  ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      drn_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drn_q   <= drn_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_start) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DRAIN;
      S_DRAIN: if (drn_q == 2'd2) state_d = S_DONE;
      S_DONE:  if (i_start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == S_RUN);
    o_done  = (state_q == S_DONE);
    drn_d   = (state_q == S_DRAIN) ? drn_q + 2'd1 : 2'd0;
    cnt_d   = cnt_q;
    if (clr)         cnt_d = '0;
    else if (accept) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    s1_vld_d = accept;
    a_s1_d   = accept ? i_a : a_s1_q;
    b_s1_d   = accept ? i_b : b_s1_q;
    z_s1_d   = accept ? i_z : z_s1_q;
    exact    = 32'(a_s1_q) * 32'(b_s1_q);
    s2_vld_d = s1_vld_q;
    err_s2_d = 33'(z_s1_q) - 33'(exact);
    abs_s2_d = err_s2_d[32] ? 33'd0 - err_s2_d : err_s2_d;
  end

  // Strict compare keeps the earliest worst sample on ties.
  assign upd_max = s2_vld_q && (abs_s2_q > max_abs_q);

  always_comb begin
    sum_err_d = sum_err_q;
    sum_abs_d = sum_abs_q;
    max_abs_d = max_abs_q;
    nz_d      = nz_q;
    if (clr) begin
      sum_err_d = '0;
      sum_abs_d = '0;
      max_abs_d = '0;
      nz_d      = '0;
    end else if (s2_vld_q) begin
      sum_err_d = sum_err_q
                + {{(SE_W-33){err_s2_q[32]}}, err_s2_q};
      sum_abs_d = sum_abs_q
                + {{(SA_W-33){1'b0}}, abs_s2_q};
      nz_d      = nz_q
                + {{(CNT_W-1){1'b0}}, |err_s2_q};
      if (upd_max) max_abs_d = abs_s2_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_vld_q  <= 1'b0;
      a_s1_q    <= '0;
      b_s1_q    <= '0;
      z_s1_q    <= '0;
      s2_vld_q  <= 1'b0;
      err_s2_q  <= '0;
      abs_s2_q  <= '0;
      sum_err_q <= '0;
      sum_abs_q <= '0;
      max_abs_q <= '0;
      nz_q      <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      a_s1_q    <= a_s1_d;
      b_s1_q    <= b_s1_d;
      z_s1_q    <= z_s1_d;
      s2_vld_q  <= s2_vld_d;
      err_s2_q  <= err_s2_d;
      abs_s2_q  <= abs_s2_d;
      sum_err_q <= sum_err_d;
      sum_abs_q <= sum_abs_d;
      max_abs_q <= max_abs_d;
      nz_q      <= nz_d;
    end
  end

  assign o_sum_err = sum_err_q;
  assign o_sum_abs = sum_abs_q;
  assign o_max_abs = max_abs_q;
  assign o_nz_cnt  = nz_q;

`ifdef MAXERR_CAPTURE_EN
  logic [15:0] a_s2_q, a_s2_d;
  logic [15:0] b_s2_q, b_s2_d;
  logic [15:0] max_a_q, max_a_d;
  logic [15:0] max_b_q, max_b_d;

  always_comb begin
    a_s2_d  = a_s1_q;
    b_s2_d  = b_s1_q;
    max_a_d = max_a_q;
    max_b_d = max_b_q;
    if (clr) begin
      max_a_d = '0;
      max_b_d = '0;
    end else if (upd_max) begin
      max_a_d = a_s2_q;
      max_b_d = b_s2_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_s2_q  <= '0;
      b_s2_q  <= '0;
      max_a_q <= '0;
      max_b_q <= '0;
    end else begin
      a_s2_q  <= a_s2_d;
      b_s2_q  <= b_s2_d;
      max_a_q <= max_a_d;
      max_b_q <= max_b_d;
    end
  end

  assign o_max_a = max_a_q;
  assign o_max_b = max_b_q;
`else
  assign o_max_a = '0;
  assign o_max_b = '0;
`endif

endmodule

// File: tb/tb_mult_err_stats.sv
// Bench for mult_err_stats: window-level model plus literal pins.
// Honours MAXERR_CAPTURE_EN when expecting o_max_a/o_max_b.
module tb_mult_err_stats;

  localparam int N  = 4;
  localparam int LG = 2;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           valid = 1'b0;
  logic           o_ready;
  logic [15:0]    ia = '0;
  logic [15:0]    ib = '0;
  logic [31:0]    iz = '0;
  logic           o_done;
  logic [34+LG-1:0] o_sum_err;
  logic [33+LG-1:0] o_sum_abs;
  logic [32:0]    o_max_abs;
  logic [CW-1:0]  o_nz_cnt;
  logic [15:0]    o_max_a;
  logic [15:0]    o_max_b;

  mult_err_stats #(.N_SAMPLES(N), .CNT_W(CW)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_valid   (valid),
    .o_ready   (o_ready),
    .i_a       (ia),
    .i_b       (ib),
    .i_z       (iz),
    .o_done    (o_done),
    .o_sum_err (o_sum_err),
    .o_sum_abs (o_sum_abs),
    .o_max_abs (o_max_abs),
    .o_nz_cnt  (o_nz_cnt),
    .o_max_a   (o_max_a),
    .o_max_b   (o_max_b)
  );

  int checks = 0;
  int failures = 0;

  // Model: accepted samples of the open window, tagged with accept edge.
  longint qa[$];
  longint qb[$];
  longint qz[$];
  int     qe[$];
  int     phase = 0;
  int     mcnt = 0;
  int     since = 0;
  int     ecount = 0;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at edge %0d",
               nm, act, exp, ecount);
    end
  endtask

  task automatic clear_model();
    qa.delete();
    qb.delete();
    qz.delete();
    qe.delete();
    mcnt = 0;
  endtask

  task automatic compare();
    longint se = 0;
    longint sa = 0;
    longint mx = 0;
    longint ma = 0;
    longint mb = 0;
    longint e;
    longint ab;
    int nz = 0;
    for (int i = 0; i < qa.size(); i++) begin
      if (qe[i] <= ecount - 2) begin
        e  = qz[i] - qa[i] * qb[i];
        ab = (e < 0) ? -e : e;
        se += e;
        sa += ab;
        if (e != 0) nz++;
        if (ab > mx) begin
          mx = ab;
          ma = qa[i];
          mb = qb[i];
        end
      end
    end
`ifndef MAXERR_CAPTURE_EN
    ma = 0;
    mb = 0;
`endif
    chk("ready", longint'(o_ready), longint'(phase == 1));
    chk("done", longint'(o_done),
        longint'(phase == 2 && since >= 3));
    chk("sum_err", longint'($signed(o_sum_err)), se);
    chk("sum_abs", longint'(o_sum_abs), sa);
    chk("max_abs", longint'(o_max_abs), mx);
    chk("nz_cnt", longint'(o_nz_cnt), longint'(nz));
    chk("max_a", longint'(o_max_a), ma & 64'hFFFF);
    chk("max_b", longint'(o_max_b), mb & 64'hFFFF);
  endtask

  task automatic step();
    if (!rst_n) begin
      clear_model();
      phase = 0;
      since = 0;
    end else begin
      case (phase)
        0: if (start) begin
          clear_model();
          phase = 1;
        end
        1: if (valid) begin
          qa.push_back(longint'($signed(ia)));
          qb.push_back(longint'($signed(ib)));
          qz.push_back(longint'($signed(iz)));
          qe.push_back(ecount + 1);
          mcnt++;
          if (mcnt == N) begin
            phase = 2;
            since = 0;
          end
        end
        default: begin
          if (since >= 3 && start) begin
            clear_model();
            phase = 1;
          end else begin
            since++;
          end
        end
      endcase
    end
    @(posedge clk);
    ecount++;
    @(negedge clk);
    compare();
  endtask

  task automatic send(longint a, longint b, longint z);
    valid = 1'b1;
    ia = 16'(a);
    ib = 16'(b);
    iz = 32'(z);
    step();
    valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_sum_err", longint'($signed(o_sum_err)), 0);
    chk("rst_ready", longint'(o_ready), 0);
    chk("rst_done", longint'(o_done), 0);
    rst_n = 1'b1;

    // Exact products
    pulse_start();
    send(3, 5, 15);
    send(-2, 7, -14);
    send(0, 9, 0);
    send(100, -1, -100);
    idle(2);
    chk("t1_done_early", longint'(o_done), 0);
    idle(1);
    chk("t1_done", longint'(o_done), 1);
    chk("t1_sum_abs", longint'(o_sum_abs), 0);
    chk("t1_nz", longint'(o_nz_cnt), 0);

    // Known errors +4,-6,0,+1
    pulse_start();
    send(3, 5, 19);
    send(-2, 7, -20);
    send(0, 9, 0);
    send(100, -1, -99);
    idle(3);
    chk("t2_sum_err", longint'($signed(o_sum_err)), -1);
    chk("t2_sum_abs", longint'(o_sum_abs), 11);
    chk("t2_max_abs", longint'(o_max_abs), 6);
    chk("t2_nz", longint'(o_nz_cnt), 3);

    // Extreme operands
    pulse_start();
    send(-32768, -32768, 0);
    send(1, 1, 1);
    send(1, 1, 1);
    send(1, 1, 1);
    idle(3);
    chk("t3_max_abs", longint'(o_max_abs), 1073741824);
    chk("t3_sum_err", longint'($signed(o_sum_err)), -1073741824);
`ifdef MAXERR_CAPTURE_EN
    chk("t3_max_a", longint'(o_max_a), 32768);
    chk("t3_max_b", longint'(o_max_b), 32768);
`endif

    // Gated valid; valid in DONE, start in RUN
    send(50, 50, 7);
    valid = 1'b1;
    pulse_start();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(i + 1, 2, 2 * (i + 1) + i);
      if (i == 1) start = 1'b1;
      step();
      start = 1'b0;
    end
    valid = 1'b1;
    idle(2);
    valid = 1'b0;
    chk("t4_done", longint'(o_done), 1);
    chk("t4_nz", longint'(o_nz_cnt), 3);
    chk("t4_sum_abs", longint'(o_sum_abs), 6);

    // Mid-window reset, then start with valid in IDLE
    pulse_start();
    send(5, 5, 30);
    send(2, 2, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_rst_sum_abs", longint'(o_sum_abs), 0);
    chk("t5_rst_ready", longint'(o_ready), 0);
    valid = 1'b1;
    ia = 16'd9;
    ib = 16'd9;
    iz = 32'd0;
    pulse_start();
    valid = 1'b0;
    send(1, 1, 3);
    send(2, 3, 6);
    send(4, 4, 16);
    send(7, -7, -50);
    idle(3);
    chk("t5_sum_err", longint'($signed(o_sum_err)), 1);
    chk("t5_nz", longint'(o_nz_cnt), 2);
    chk("t5_max_abs", longint'(o_max_abs), 2);

    // Back-to-back windows
    pulse_start();
    chk("t6_clr_done", longint'(o_done), 0);
    chk("t6_clr_sum_abs", longint'(o_sum_abs), 0);
    chk("t6_ready", longint'(o_ready), 1);
    send(0, 0, 7);
    send(10, 10, 100);
    send(3, 3, 9);
    send(-1, -1, 1);
    idle(3);
    chk("t6_sum_err", longint'($signed(o_sum_err)), 7);
    chk("t6_max_abs", longint'(o_max_abs), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
